// File: rtl/instr_encoder.sv
// Program-load encoder: assembles MIPS instruction words from field
// descriptions and writes them to instruction memory at an auto-incrementing
// word address.
module instr_encoder #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_wen,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              wrapped
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                err_q, err_d;
  logic                wrapped_q, wrapped_d;
  logic                stop_pend_q, stop_pend_d;

  logic [WORD_W-1:0]   enc_word;
  logic                enc_legal;

  // Instruction word assembly from the current description
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (in_kind)
      3'd0:    enc_word = {6'h00, in_rs, in_rt, in_rd, in_shamt, in_funct};
      3'd1:    enc_word = {6'h08, in_rs, in_rt, in_imm};
      3'd2:    enc_word = {6'h04, in_rs, in_rt, in_imm};
      3'd3:    enc_word = {6'h02, in_target};
      3'd4:    enc_word = {6'h23, in_rs, in_rt, in_imm};
      3'd5:    enc_word = {6'h2B, in_rs, in_rt, in_imm};
      default: enc_legal = 1'b0;
    endcase
  end

  // Next-state, datapath updates and state-decoded outputs
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    count_d     = count_q;
    err_d       = err_q;
    wrapped_d   = wrapped_q;
    stop_pend_d = stop_pend_q;
    in_ready    = 1'b0;
    imem_wen    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d     = start_addr;
          count_d   = '0;
          err_d     = 1'b0;
          wrapped_d = 1'b0;
          state_d   = S_READY;
        end
      end
      S_READY: begin
        in_ready = !stop;
        if (stop) begin
          state_d = S_IDLE;
        end else if (in_valid) begin
          if (enc_legal) begin
            data_d      = enc_word;
            addr_d      = ptr_q;
            stop_pend_d = 1'b0;
            state_d     = S_WRITE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        imem_wen    = 1'b1;
        stop_pend_d = stop_pend_q | stop;
        if (imem_ready) begin
          ptr_d       = ptr_q + ADDR_W'(1);
          count_d     = count_q + CNT_W'(1);
          if (&ptr_q) wrapped_d = 1'b1;
          stop_pend_d = 1'b0;
          state_d     = (stop_pend_q | stop) ? S_IDLE : S_READY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      wrapped_q   <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      count_q     <= count_d;
      err_q       <= err_d;
      wrapped_q   <= wrapped_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign imem_addr  = addr_q;
  assign imem_wdata = data_q;
  assign count      = count_q;
  assign err        = err_q;
  assign wrapped    = wrapped_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with hand-computed instruction words.
module tb_instr_encoder;

  localparam int unsigned ADDR_W = 10;

  logic              clk;
  logic              arst_n;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              stop;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [4:0]        in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              imem_wen;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic [ADDR_W:0]   count;
  logic              err;
  logic              wrapped;

  int n_checks = 0;
  int n_errors = 0;

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .start      (start),
    .start_addr (start_addr),
    .stop       (stop),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_shamt   (in_shamt),
    .in_funct   (in_funct),
    .in_imm     (in_imm),
    .in_target  (in_target),
    .imem_wen   (imem_wen),
    .imem_ready (imem_ready),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .count      (count),
    .err        (err),
    .wrapped    (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_wen"},      32'(imem_wen), 32'd0);
    check({tag, "_addr"},     32'(imem_addr), 32'd0);
    check({tag, "_wdata"},    imem_wdata, 32'd0);
    check({tag, "_busy"},     32'(busy), 32'd0);
    check({tag, "_count"},    32'(count), 32'd0);
    check({tag, "_err"},      32'(err), 32'd0);
    check({tag, "_wrapped"},  32'(wrapped), 32'd0);
  endtask

  task automatic set_desc(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                          input logic [15:0] imm, input logic [25:0] tgt);
    in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_funct = fn; in_imm = imm; in_target = tgt;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] a);
    start = 1'b1; start_addr = a;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Called at a negedge with the encoder in READY and the description set up.
  // Accepts it, holds imem_ready low for 'stall' cycles, then completes.
  task automatic send(input string tag, input logic [ADDR_W-1:0] exp_addr,
                      input logic [31:0] exp_data, input int stall, input int exp_cnt);
    in_valid = 1'b1;
    #1;
    check({tag, "_ready_pre"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_wen"},   32'(imem_wen), 32'd1);
    check({tag, "_addr"},  32'(imem_addr), 32'(exp_addr));
    check({tag, "_data"},  imem_wdata, exp_data);
    check({tag, "_in_ready_w"}, 32'(in_ready), 32'd0);
    if (stall > 0) begin
      imem_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check({tag, "_stall_wen"},   32'(imem_wen), 32'd1);
        check({tag, "_stall_addr"},  32'(imem_addr), 32'(exp_addr));
        check({tag, "_stall_data"},  imem_wdata, exp_data);
        check({tag, "_stall_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_stall_count"}, 32'(count), 32'(exp_cnt - 1));
      end
      imem_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, "_count"}, 32'(count), 32'(exp_cnt));
    check({tag, "_wen_done"}, 32'(imem_wen), 32'd0);
  endtask

  initial begin
    arst_n = 1'b0; start = 1'b0; start_addr = '0; stop = 1'b0;
    in_valid = 1'b0; imem_ready = 1'b1;
    set_desc(3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Basic ADDI / ALU_R session at 0x010
    do_start(10'h010);
    set_desc(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0);
    send("addi", 10'h010, 32'h2022_0005, 0, 1);
    set_desc(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0);
    send("add", 10'h011, 32'h0022_1820, 0, 2);

    // Memory-access, branch and jump kinds
    set_desc(3'd4, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0);
    send("lw", 10'h012, 32'h8FA8_0004, 0, 3);
    set_desc(3'd5, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'd8, 26'd0);
    send("sw", 10'h013, 32'hAFA8_0008, 0, 4);
    set_desc(3'd2, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0);
    send("beq", 10'h014, 32'h1085_FFFF, 0, 5);
    set_desc(3'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10);
    send("j", 10'h015, 32'h0800_0010, 0, 6);

    // Back-pressure: sll with shamt, memory stalls for 5 cycles
    set_desc(3'd0, 5'd3, 5'd4, 5'd5, 5'd2, 6'h00, 16'd0, 26'd0);
    send("sll_stall", 10'h016, 32'h0064_2880, 5, 7);

    // Illegal kind: dropped, err set, pointer unchanged
    set_desc(3'd7, 5'd1, 5'd1, 5'd1, 5'd0, 6'd0, 16'd1, 26'd0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("ill_err", 32'(err), 32'd1);
    check("ill_wen", 32'(imem_wen), 32'd0);
    check("ill_ready", 32'(in_ready), 32'd1);
    check("ill_count", 32'(count), 32'd7);
    set_desc(3'd1, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0);
    send("post_ill", 10'h017, 32'h2001_1234, 0, 8);
    check("err_sticky", 32'(err), 32'd1);

    // stop in READY returns to IDLE; start is ignored there otherwise
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_idle_busy", 32'(busy), 32'd0);

    // Pointer wrap from 0x3FF; start clears err/count
    do_start(10'h3FF);
    check("start_clr_err", 32'(err), 32'd0);
    check("start_clr_count", 32'(count), 32'd0);
    set_desc(3'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3FF_FFFF);
    send("wrap0", 10'h3FF, 32'h0BFF_FFFF, 0, 1);
    check("wrapped_set", 32'(wrapped), 32'd1);
    set_desc(3'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    send("wrap1", 10'h000, 32'h1000_0000, 0, 2);
    check("wrapped_sticky", 32'(wrapped), 32'd1);

    // stop seen mid-WRITE: write completes, then IDLE
    set_desc(3'd1, 5'd7, 5'd7, 5'd0, 5'd0, 6'd0, 16'h00FF, 26'd0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    imem_ready = 1'b0;
    stop = 1'b1;
    check("sw_wen", 32'(imem_wen), 32'd1);
    check("sw_addr", 32'(imem_addr), 32'h001);
    check("sw_data", imem_wdata, 32'h20E7_00FF);
    @(negedge clk);
    stop = 1'b0;
    check("sw_busy_hold", 32'(busy), 32'd1);
    @(negedge clk);
    imem_ready = 1'b1;
    check("sw_wen_hold", 32'(imem_wen), 32'd1);
    @(negedge clk);
    check("sw_done_busy", 32'(busy), 32'd0);
    check("sw_done_count", 32'(count), 32'd3);
    check("sw_done_ready", 32'(in_ready), 32'd0);

    // stop together with in_valid in READY: nothing accepted
    do_start(10'h020);
    set_desc(3'd1, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'd1, 26'd0);
    stop = 1'b1; in_valid = 1'b1;
    #1;
    check("sv_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    stop = 1'b0; in_valid = 1'b0;
    check("sv_busy", 32'(busy), 32'd0);
    check("sv_wen", 32'(imem_wen), 32'd0);
    check("sv_count", 32'(count), 32'd0);

    // Reset in the middle of a stalled write
    do_start(10'h055);
    set_desc(3'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd3, 26'd0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    imem_ready = 1'b0;
    check("rw_wen", 32'(imem_wen), 32'd1);
    #2;
    arst_n = 1'b0;
    #1;
    check_reset_outputs("rw");
    @(negedge clk);
    arst_n = 1'b1;
    imem_ready = 1'b1;
    @(negedge clk);
    check("rw_after_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program-load encoder for the single-cycle MIPS core: the write-side counterpart of the opcode decoder. It accepts instruction descriptions (kind plus register/immediate fields) over a valid/ready handshake, assembles the 32-bit MIPS word for the six supported instruction kinds, and writes it into instruction memory at an auto-incrementing word address. It sits between the testbench/boot loader and the instruction memory write port, and is used to load programs before the core is released from reset.

## Interface
- ADDR_W, 10, instruction-memory word-address width
- clk  in  1  clock, all state updates on rising edge
- arst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; loads write pointer from start_addr; clears count/err/wrapped
- start_addr  in  ADDR_W  first word address
- stop  in  1  level; ends the load session
- in_valid  in  1  instruction description valid
- in_ready  out  1  encoder accepts description this cycle
- in_kind  in  3  0 ALU_R, 1 ADDI, 2 BEQ, 3 JUMP, 4 LW, 5 SW; 6-7 illegal
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register / shift fields
- in_funct  in  6  R-type function field
- in_imm  in  16  I-type immediate
- in_target  in  26  J-type target
- imem_wen  out  1  write request to instruction memory
- imem_ready  in  1  memory accepts write this cycle
- imem_addr  out  ADDR_W  word address of write
- imem_wdata  out  32  encoded instruction
- busy  out  1  state != IDLE
- count  out  ADDR_W+1  words written since last start, wraps modulo 2^(ADDR_W+1)
- err  out  1  sticky: illegal in_kind accepted
- wrapped  out  1  sticky: write pointer wrapped past all-ones

## Operation
- States: IDLE, READY, WRITE.
- IDLE: in_ready=0, imem_wen=0. start -> load ptr=start_addr, clear count/err/wrapped, go READY. stop is ignored in IDLE.
- READY: in_ready = !stop. If stop=1 -> IDLE (stop has priority; no description is accepted that cycle). If in_valid && in_ready:
  - legal kind: register encoded word into the data register, addr register <= ptr, go WRITE;
  - illegal kind: set err, drop the description, stay in READY.
- WRITE: imem_wen=1; imem_addr/imem_wdata held stable until imem_ready=1. On the handshake: ptr <= ptr+1 (modulo 2^ADDR_W; set wrapped if ptr was all-ones), count <= count+1, then go to IDLE if stop was seen at any cycle during WRITE (latched stop_pending), else go to READY.
- start is honoured only in IDLE; it is ignored in READY/WRITE.
- Encoding (op field in hex):
  - ALU_R: {00, rs, rt, rd, shamt, funct}
  - ADDI: {08, rs, rt, imm}
  - BEQ: {04, rs, rt, imm}
  - JUMP: {02, target}
  - LW: {23, rs, rt, imm}
  - SW: {2B, rs, rt, imm}
- Fields that are unused for a given kind are ignored.

## Timing
- Reset (async, arst_n low): state=IDLE, in_ready=0, imem_wen=0, imem_addr=0, imem_wdata=0, busy=0, count=0, err=0, wrapped=0, ptr=0, stop_pending=0. Reset mid-WRITE abandons the write immediately.
- Accept at edge N -> imem_wen=1 with valid addr/data from N+1 until the edge at which imem_ready=1.
- in_ready is 0 throughout WRITE. Maximum throughput is one word per 2 cycles with imem_ready tied high.
- start at edge N -> busy=1 and in_ready=1 from N+1 (if stop=0).
- count, ptr and wrapped update on the same edge as the memory handshake.
- in_ready depends combinationally on state and stop only, never on in_valid.

## Test plan
- start_addr=0x010; ADDI rs=1 rt=2 imm=5, then ALU_R rs=1 rt=2 rd=3 funct=0x20 -> writes 0x20220005 @0x010 and 0x00221820 @0x011; count=2.
- LW rs=29 rt=8 imm=4; SW rs=29 rt=8 imm=8; BEQ rs=4 rt=5 imm=0xFFFF; JUMP target=0x10 -> 0x8FA80004, 0xAFA80008, 0x1085FFFF, 0x08000010 at consecutive addresses.
- Hold imem_ready=0 for 5 cycles during WRITE -> imem_wen/addr/data stable, in_ready=0, count unchanged until ready.
- in_kind=7 -> err=1, no imem_wen, ptr unchanged; next legal description is still written at the same address; start clears err.
- start_addr=0x3FF (ADDR_W=10), two writes -> addresses 0x3FF then 0x000; wrapped=1.
- stop asserted during WRITE -> write completes, then IDLE (busy=0); stop and in_valid together in READY -> nothing accepted, IDLE next cycle; arst_n low mid-WRITE -> all outputs at reset values immediately.
